morse_hex_receiver: RTL and testbench

- Receives a single Morse key input and decodes each keyed character into a 4-bit hex digit (0-9, A-F).
- Produces the 4-bit code that drives the board's seven-segment hex digit decoder, plus valid and error pulses for the trainer logic.
- Measures mark and space durations against a programmable Morse unit, accumulates dots and dashes, and looks up the completed symbol.

---
 rtl/morse_hex_receiver_if.sv | 20 ++
 rtl/morse_hex_receiver.sv | 186 ++++++++++++++++++
 tb/tb_morse_hex_receiver.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/morse_hex_receiver_if.sv
// Key input and decoded-character outputs of the Morse hex receiver.
// The receiver is the slave; the stimulus/trainer side is the master.
interface morse_hex_receiver_if;
  logic       key;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       error;
  logic [2:0] sym_len;
  logic       busy;

  modport slave (
    input  key,
    output digit_out, digit_valid, error, sym_len, busy
  );

  modport master (
    output key,
    input  digit_out, digit_valid, error, sym_len, busy
  );
endinterface

// File: rtl/morse_hex_receiver.sv
// Morse key receiver: synchronizes and debounces the key, times marks/spaces in
// Morse units, collects up to five elements and decodes them to a hex digit.
module morse_hex_receiver #(
  parameter int UNIT_CYCLES     = 50,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  morse_hex_receiver_if.slave  bus
);

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_GAP = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DUR_SAT  = CNT_W'(7 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MARK = 2'd1, S_SPACE = 2'd2} state_e;

  // Returns {hit, code}; the first keyed element sits at bit (n-1) of p.
  function automatic logic [4:0] lookup(input logic [2:0] n, input logic [4:0] p);
    case ({n, p})
      {3'd5, 5'b11111}: lookup = {1'b1, 4'h0};
      {3'd5, 5'b01111}: lookup = {1'b1, 4'h1};
      {3'd5, 5'b00111}: lookup = {1'b1, 4'h2};
      {3'd5, 5'b00011}: lookup = {1'b1, 4'h3};
      {3'd5, 5'b00001}: lookup = {1'b1, 4'h4};
      {3'd5, 5'b00000}: lookup = {1'b1, 4'h5};
      {3'd5, 5'b10000}: lookup = {1'b1, 4'h6};
      {3'd5, 5'b11000}: lookup = {1'b1, 4'h7};
      {3'd5, 5'b11100}: lookup = {1'b1, 4'h8};
      {3'd5, 5'b11110}: lookup = {1'b1, 4'h9};
      {3'd2, 5'b00001}: lookup = {1'b1, 4'hA};
      {3'd4, 5'b01000}: lookup = {1'b1, 4'hB};
      {3'd4, 5'b01010}: lookup = {1'b1, 4'hC};
      {3'd3, 5'b00100}: lookup = {1'b1, 4'hD};
      {3'd1, 5'b00000}: lookup = {1'b1, 4'hE};
      {3'd4, 5'b00010}: lookup = {1'b1, 4'hF};
      default:          lookup = {1'b0, 4'h0};
    endcase
  endfunction

  logic             sync1_q, sync2_q, kd_q, kd_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d, dur_q, dur_d;
  state_e           state_q, state_d;
  logic [4:0]       sh_q, sh_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d, abort_q, abort_d;
  logic [3:0]       digit_q, digit_d;
  logic             valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic [2:0]       sym_len_q, sym_len_d;
  logic             kd_rise_s, kd_fall_s;
  logic [4:0]       lut_s;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      kd_q      <= 1'b0;
      db_cnt_q  <= '0;
      dur_q     <= '0;
      state_q   <= S_IDLE;
      sh_q      <= 5'd0;
      cnt_q     <= 3'd0;
      ovf_q     <= 1'b0;
      abort_q   <= 1'b0;
      digit_q   <= 4'h0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      sym_len_q <= 3'd0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.key;
      sync2_q   <= sync1_q;
      kd_q      <= kd_d;
      db_cnt_q  <= db_cnt_d;
      dur_q     <= dur_d;
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      abort_q   <= abort_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      sym_len_q <= sym_len_d;
      busy_q    <= busy_d;
    end
  end

  // Debounce and the shared mark/space duration counter (restarts at 1 on a kd edge).
  always_comb begin
    kd_d     = kd_q;
    db_cnt_d = '0;
    if (sync2_q != kd_q) begin
      if (db_cnt_q == DB_LAST) begin
        kd_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
    if (kd_d != kd_q) begin
      dur_d = CNT_W'(1);
    end else if (dur_q == DUR_SAT) begin
      dur_d = dur_q;
    end else begin
      dur_d = dur_q + CNT_W'(1);
    end
    kd_rise_s = kd_d & ~kd_q;
    kd_fall_s = ~kd_d & kd_q;
  end

  // Character FSM, element accumulation and result evaluation.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    abort_d   = abort_q;
    digit_d   = digit_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    sym_len_d = sym_len_q;
    lut_s     = lookup(cnt_q, sh_q);
    case (state_q)
      S_IDLE: begin
        // Level check also catches a press that coincided with the previous character's end.
        if (kd_rise_s || kd_q) begin
          state_d = S_MARK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        if (dur_q >= DUR_SAT) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (kd_fall_s) begin
          sh_d = {sh_q[3:0], (dur_q >= DASH_MIN)};
          if (cnt_q == 3'd5) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
          state_d = S_SPACE;
        end else begin
          state_d = S_MARK;
        end
      end
      S_SPACE: begin
        if (dur_q == CHAR_GAP) begin
          if (lut_s[4] && !ovf_q && !abort_q) begin
            digit_d = lut_s[3:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          sym_len_d = cnt_q;
          sh_d      = 5'd0;
          cnt_d     = 3'd0;
          ovf_d     = 1'b0;
          abort_d   = 1'b0;
          state_d   = S_IDLE;
        end else if (kd_rise_s) begin
          state_d = S_MARK;
        end else begin
          state_d = S_SPACE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign bus.digit_out   = digit_q;
  assign bus.digit_valid = valid_q;
  assign bus.error       = err_q;
  assign bus.sym_len     = sym_len_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_morse_hex_receiver.sv
// Directed bench for morse_hex_receiver with UNIT_CYCLES=10, DEBOUNCE_CYCLES=2.
module tb_morse_hex_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  morse_hex_receiver_if bus ();

  morse_hex_receiver #(
    .UNIT_CYCLES(10),
    .DEBOUNCE_CYCLES(2),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int n_long = 0;
  int base_v = 0;
  int base_e = 0;
  logic [2:0] last_sym = 3'd0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  // Pulse monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.digit_valid === 1'b1) begin
      n_valid  <= n_valid + 1;
      last_sym <= bus.sym_len;
    end
    if (bus.error === 1'b1) begin
      n_err    <= n_err + 1;
      last_sym <= bus.sym_len;
    end
    if (bus.digit_valid === 1'b1 && bus.error === 1'b1) n_both <= n_both + 1;
    if ((bus.digit_valid === 1'b1 && prev_v) || (bus.error === 1'b1 && prev_e)) n_long <= n_long + 1;
    prev_v <= (bus.digit_valid === 1'b1);
    prev_e <= (bus.error === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic begin_char();
    base_v = n_valid;
    base_e = n_err;
  endtask

  task automatic elem(input int len);
    bus.key = 1'b1;
    repeat (len) @(negedge clk);
    bus.key = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic end_char(input string tag, input int exp_v, input int exp_e,
                          input logic [3:0] exp_d, input logic [2:0] exp_sym);
    repeat (45) @(negedge clk);
    chk({tag, "_valid"}, n_valid - base_v, exp_v);
    chk({tag, "_err"},   n_err - base_e,   exp_e);
    chk({tag, "_digit"}, {28'd0, bus.digit_out}, {28'd0, exp_d});
    chk({tag, "_sym"},   {29'd0, last_sym},      {29'd0, exp_sym});
    chk({tag, "_idle"},  {31'd0, bus.busy},      32'd0);
  endtask

  initial begin
    int found;
    bus.key = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digit", {28'd0, bus.digit_out}, 32'd0);
    chk("rst_valid", {31'd0, bus.digit_valid}, 32'd0);
    chk("rst_err",   {31'd0, bus.error}, 32'd0);
    chk("rst_sym",   {29'd0, bus.sym_len}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ".-" -> A
    begin_char();
    elem(10);
    chk("busy_mid", {31'd0, bus.busy}, 32'd1);
    elem(30);
    end_char("a", 1, 0, 4'hA, 3'd2);

    // 19-cycle mark is a dot, 20-cycle mark is a dash
    begin_char(); elem(19); end_char("dot19", 1, 0, 4'hE, 3'd1);
    begin_char(); elem(20); end_char("dash20", 0, 1, 4'hE, 3'd1);

    begin_char();
    for (int i = 0; i < 5; i++) elem(10);
    end_char("five", 1, 0, 4'h5, 3'd5);

    begin_char();
    elem(30);
    for (int i = 0; i < 4; i++) elem(10);
    end_char("six", 1, 0, 4'h6, 3'd5);

    begin_char();
    for (int i = 0; i < 6; i++) elem(10);
    end_char("ovf", 0, 1, 4'h6, 3'd5);

    begin_char(); elem(10); end_char("after_ovf", 1, 0, 4'hE, 3'd1);

    begin_char();
    elem(10); elem(30); elem(10); elem(30);
    end_char("unlisted", 0, 1, 4'hE, 3'd4);

    begin_char(); elem(80); end_char("abort", 0, 1, 4'hE, 3'd1);

    // Glitches during the space must not extend or split the character
    begin_char();
    bus.key = 1'b1;
    repeat (10) @(negedge clk);
    bus.key = 1'b0;
    found = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.key = ((k % 5) == 0 && k <= 25) ? 1'b1 : 1'b0;
      if (bus.digit_valid === 1'b1 || bus.error === 1'b1) begin
        found = k;
        break;
      end
    end
    bus.key = 1'b0;
    chk("lat_window", {31'd0, (found >= 34 && found <= 36)}, 32'd1);
    end_char("glitch_space", 1, 0, 4'hE, 3'd1);

    // Bounce at press onset yields a single element
    begin_char();
    bus.key = 1'b1; @(negedge clk);
    bus.key = 1'b0; @(negedge clk);
    bus.key = 1'b1; @(negedge clk);
    bus.key = 1'b0; @(negedge clk);
    elem(10);
    end_char("bounce_on", 1, 0, 4'hE, 3'd1);

    // Reset in the gap after "." discards the character
    begin_char();
    bus.key = 1'b1;
    repeat (10) @(negedge clk);
    bus.key = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rstmid_digit", {28'd0, bus.digit_out}, 32'd0);
    chk("rstmid_sym",   {29'd0, bus.sym_len}, 32'd0);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("rstmid_nopulse", (n_valid - base_v) + (n_err - base_e), 32'd0);

    begin_char();
    elem(30); elem(10); elem(10);
    end_char("d", 1, 0, 4'hD, 3'd3);

    chk("never_both", n_both, 32'd0);
    chk("one_cycle_pulses", n_long, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
